// File: rtl/cigar_encoder_if.sv
// Bundle between the traceback stage, the CIGAR run-length encoder and the host
// that drains finished records.
`ifndef BP_WIDTH
`define BP_WIDTH 2
`endif

interface cigar_encoder_if #(
  parameter int OP_WIDTH  = `BP_WIDTH,
  parameter int LEN_WIDTH = 12
);
  logic [OP_WIDTH-1:0]  op_i;
  logic                 op_valid_i;
  logic                 tb_done_i;
  logic                 stall_o;
  logic [1:0]           rec_op_o;
  logic [LEN_WIDTH-1:0] rec_len_o;
  logic                 rec_last_o;
  logic                 rec_valid_o;
  logic                 rec_ready_i;
  logic                 busy_o;
  logic                 err_o;

  modport slave (
    input  op_i, op_valid_i, tb_done_i, rec_ready_i,
    output stall_o, rec_op_o, rec_len_o, rec_last_o, rec_valid_o, busy_o, err_o
  );

  modport master (
    output op_i, op_valid_i, tb_done_i, rec_ready_i,
    input  stall_o, rec_op_o, rec_len_o, rec_last_o, rec_valid_o, busy_o, err_o
  );
endinterface

// File: rtl/cigar_encoder.sv
// Run-length encodes traceback ops (M/I/D) into CIGAR records queued in a small
// synchronous FIFO, with backpressure and a sticky error flag.
`ifndef BP_WIDTH
`define BP_WIDTH 2
`endif

module cigar_encoder #(
  parameter int OP_WIDTH   = `BP_WIDTH,
  parameter int LEN_WIDTH  = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_i,
  cigar_encoder_if.slave    bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = 2 + LEN_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX  = '1;
  localparam logic [AW:0]          FULL_AT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]          STALL_AT = (AW+1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t               state_reg, state_next;
  logic [1:0]           cur_op_reg, cur_op_next;
  logic [LEN_WIDTH-1:0] cur_len_reg, cur_len_next;

  logic                 push, push_last;
  logic [1:0]           push_op;
  logic [LEN_WIDTH-1:0] push_len;
  logic                 op_legal, op_bad;

  logic [RW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          count_reg;
  logic                 err_reg;
  logic                 pop, fifo_full, push_ok, drop;
  logic [RW-1:0]        head;

  // Ops arriving while a flush is pending, or with the reserved code, are dropped.
  assign op_bad   = bus.op_valid_i && ((bus.op_i >= OP_WIDTH'(3)) || (state_reg == FLUSH));
  assign op_legal = bus.op_valid_i && !op_bad;

  always_comb begin
    state_next   = state_reg;
    cur_op_next  = cur_op_reg;
    cur_len_next = cur_len_reg;
    push         = 1'b0;
    push_op      = cur_op_reg;
    push_len     = cur_len_reg;
    push_last    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (op_legal) begin
          cur_op_next  = bus.op_i[1:0];
          cur_len_next = LEN_WIDTH'(1);
          state_next   = bus.tb_done_i ? FLUSH : RUN;
        end else if (bus.tb_done_i) begin
          push      = 1'b1;
          push_op   = 2'b00;
          push_len  = '0;
          push_last = 1'b1;
        end
      end
      RUN: begin
        if (op_legal) begin
          if (bus.op_i[1:0] == cur_op_reg && cur_len_reg != LEN_MAX) begin
            cur_len_next = cur_len_reg + LEN_WIDTH'(1);
          end else begin
            push         = 1'b1;
            cur_op_next  = bus.op_i[1:0];
            cur_len_next = LEN_WIDTH'(1);
          end
          state_next = bus.tb_done_i ? FLUSH : RUN;
        end else if (bus.tb_done_i) begin
          push         = 1'b1;
          push_last    = 1'b1;
          cur_len_next = '0;
          state_next   = IDLE;
        end
      end
      FLUSH: begin
        push         = 1'b1;
        push_last    = 1'b1;
        cur_len_next = '0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_reg   <= IDLE;
      cur_op_reg  <= 2'b00;
      cur_len_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cur_op_reg  <= cur_op_next;
      cur_len_reg <= cur_len_next;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop       = (count_reg != '0) && bus.rec_ready_i;
  assign fifo_full = (count_reg == FULL_AT);
  assign push_ok   = push && (!fifo_full || pop);
  assign drop      = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      err_reg <= err_reg | drop | op_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= {push_op, push_len, push_last};
  end

  // Slots are not cleared on reset, so the head is masked while the FIFO is empty.
  assign head            = mem[rd_ptr_reg];
  assign bus.rec_valid_o = (count_reg != '0);
  assign bus.rec_op_o    = bus.rec_valid_o ? head[RW-1 -: 2] : 2'b00;
  assign bus.rec_len_o   = bus.rec_valid_o ? head[LEN_WIDTH:1] : '0;
  assign bus.rec_last_o  = bus.rec_valid_o ? head[0] : 1'b0;
  assign bus.stall_o     = (count_reg >= STALL_AT) || (state_reg == FLUSH);
  assign bus.busy_o      = (state_reg != IDLE) || (count_reg != '0);
  assign bus.err_o       = err_reg;
endmodule

// File: doc/cigar_encoder.md
CIGAR_ENCODER -- requirements
Module: cigar_encoder

Interface
REQ-001 SHALL have parameter OP_WIDTH, default `BP_WIDTH (2), the width of one traceback operation code.
REQ-002 SHALL have parameter LEN_WIDTH, default 12, the width of a run-length field.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, the number of record slots (power of two).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port op_i, input, OP_WIDTH, traceback operation: 00 = M (match/mismatch), 01 = I (insertion), 10 = D (deletion), 11 = reserved.
REQ-007 SHALL have port op_valid_i, input, 1, meaning op_i is valid this cycle; driven from traceback alignment_valid.
REQ-008 SHALL have port tb_done_i, input, 1, a single-cycle pulse marking the end of the current alignment; driven from traceback done.
REQ-009 SHALL have port stall_o, output, 1, backpressure to the traceback stage.
REQ-010 SHALL have port rec_op_o, output, 2, the op code of the head record.
REQ-011 SHALL have port rec_len_o, output, LEN_WIDTH, the run length of the head record.
REQ-012 SHALL have port rec_last_o, output, 1, set when the head record is the final record of an alignment.
REQ-013 SHALL have port rec_valid_o, output, 1, set when a head record is available.
REQ-014 SHALL have port rec_ready_i, input, 1, set when the host accepts the head record.
REQ-015 SHALL have port busy_o, output, 1, set while a run is open, a flush is pending, or the FIFO is non-empty.
REQ-016 SHALL have port err_o, output, 1, a sticky error flag (overflow or reserved op).

Function
REQ-017 SHALL run-length encode ops in arrival order, with no reordering; traceback order (end to start) is preserved.
REQ-018 SHALL implement states IDLE (no open run), RUN (run open: cur_op, cur_len), and FLUSH (final record pending).
REQ-019 SHALL, in IDLE, on op_valid_i with a legal op, set cur_op = op_i and cur_len = 1, then go to RUN.
REQ-020 SHALL, in RUN, on op_valid_i with op_i == cur_op and cur_len < 2^LEN_WIDTH-1, increment cur_len; no record is pushed.
REQ-021 SHALL, in RUN, on op_valid_i with op_i != cur_op, or with cur_len == 2^LEN_WIDTH-1 (saturation split), push {cur_op, cur_len, last=0} and restart the run with op_i and length 1.
REQ-022 SHALL, on tb_done_i without op_valid_i, push {cur_op, cur_len, last=1} in that cycle from RUN and return to IDLE.
REQ-023 SHALL, on tb_done_i in IDLE (empty alignment), push {00, 0, last=1}.
REQ-024 SHALL, on tb_done_i with op_valid_i in the same cycle, process the op first per REQ-019..021, go to FLUSH, and push the last=1 record on the next cycle, then go to IDLE.
REQ-025 SHALL, for op_valid_i during FLUSH or a reserved op 11, ignore the op and set err_o.
REQ-026 SHALL push at most one record per cycle into a FIFO_DEPTH-entry synchronous FIFO.
REQ-027 SHALL make a pushed record visible on rec_* the next cycle, so latency from the terminating op or done to rec_valid_o is 1 cycle when the FIFO is empty.
REQ-028 SHALL hold rec_valid_o = FIFO non-empty; rec_* hold stable while rec_valid_o && !rec_ready_i; a pop occurs on rec_valid_o && rec_ready_i.
REQ-029 SHALL assert stall_o combinationally while FIFO occupancy >= FIFO_DEPTH-2 or state == FLUSH, reserving headroom for REQ-024.
REQ-030 SHALL not require the upstream to send op_valid_i while stall_o is high; if a push is attempted while the FIFO is full and no pop occurs that cycle, the record SHALL be dropped and err_o set.
REQ-031 SHALL, when the FIFO is full and a push and pop occur in the same cycle, complete both; occupancy is unchanged and nothing is dropped.
REQ-032 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with occupancy tracked in log2(FIFO_DEPTH)+1 bits.

Reset
REQ-033 SHALL, while reset_i is high at a clock edge, go to IDLE, set cur_len = 0, empty the FIFO, and clear err_o.
REQ-034 SHALL, after reset, drive rec_op_o = 0, rec_len_o = 0, rec_last_o = 0, rec_valid_o = 0, stall_o = 0, busy_o = 0, err_o = 0.
REQ-035 SHALL, on reset mid-alignment, discard the open run, pending flush, and queued records, with no partial record emitted.

Verification
REQ-036 Ops M,M,M,I,D,D then done, rec_ready_i = 1 -> records (00,3,0), (01,1,0), (10,2,1); err_o = 0.
REQ-037 LEN_WIDTH = 4, 17 consecutive M then done -> records (00,15,0), (00,2,1).
REQ-038 done alone in IDLE -> single record (00,0,1); M then (I with done in the same cycle) -> (00,1,0), (01,1,1), where the last record appears 2 cycles after done.
REQ-039 rec_ready_i = 0, alternating M/I ops -> stall_o rises at occupancy 6; upstream stops; no drop; after rec_ready_i = 1, all records drain in order with err_o = 0.
REQ-040 Forced push at occupancy 8 with no pop -> record dropped, err_o = 1 and held until reset_i.
REQ-041 reset_i pulsed with 3 records queued and a run open -> next cycle rec_valid_o = 0, busy_o = 0; a new alignment M,done -> (00,1,1).
